// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer.
// One 1-bit full-adder slice (two half adders plus an OR) is reused across
// all WIDTH bit positions, one bit per clock, LSB first.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high reset
//   start  - operation request, accepted in IDLE or DONE
//   a, b   - WIDTH-bit operands, captured on the accept edge
//   cin    - carry-in, captured on the accept edge
//   busy   - high while the adder slice is in use
//   done   - one-cycle pulse, sum/cout valid from this cycle
//   sum    - registered result, held until the next completion
//   cout   - registered carry-out, held until the next completion

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_add_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CNT_W-1:0] count;

  logic ha1_s, ha1_c;
  logic ha2_s, ha2_c;
  logic new_carry;

  half_adder u_ha1 (
    .x (op_a[0]),
    .y (op_b[0]),
    .s (ha1_s),
    .c (ha1_c)
  );

  half_adder u_ha2 (
    .x (ha1_s),
    .y (carry),
    .s (ha2_s),
    .c (ha2_c)
  );

  assign new_carry = ha1_c | ha2_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            acc   <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= S_SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end

        S_SHIFT: begin
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          acc   <= {ha2_s, acc[WIDTH-1:1]};
          carry <= new_carry;
          count <= count + CNT_W'(1);
          // Last bit: publish the accumulator including this cycle's bit,
          // so sum never exposes a partially built value.
          if (count == CNT_W'(WIDTH - 1)) begin
            sum   <= {ha2_s, acc[WIDTH-1:1]};
            cout  <= new_carry;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed testbench for serial_add_ctrl (WIDTH=8 main instance, WIDTH=2
// instance for an exhaustive sweep).

module tb_serial_add_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  logic       start2;
  logic [1:0] a2;
  logic [1:0] b2;
  logic       cin2;
  logic       busy2;
  logic       done2;
  logic [1:0] sum2;
  logic       cout2;

  int         checks;
  int         errors;
  logic [7:0] prev_sum;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .start (start2),
    .a     (a2),
    .b     (b2),
    .cin   (cin2),
    .busy  (busy2),
    .done  (done2),
    .sum   (sum2),
    .cout  (cout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    a = 8'hFF; b = 8'hFF; cin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b expected 0 0 00 0",
               busy, done, sum, cout);
    end
    start = 1'b0;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b expected 0 0", busy, done);
    end
    prev_sum = 8'h00;
  endtask

  // One complete operation from IDLE, checking every cycle.
  task automatic test_op(input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic tc, input logic [7:0] es, input logic ec);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~ta; b = ~tb_v; cin = ~tc;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL accept_%h_%h: busy=%b done=%b expected 1 0", ta, tb_v, busy, done);
    end
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (i < 8) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || sum !== prev_sum) begin
          errors++;
          $display("FAIL shift_%h_%h cyc%0d: busy=%b done=%b sum=%h expected 1 0 %h",
                   ta, tb_v, i, busy, done, sum, prev_sum);
        end
      end else begin
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
          errors++;
          $display("FAIL done_%h_%h: busy=%b done=%b expected 0 1", ta, tb_v, busy, done);
        end
        checks++;
        if (sum !== es || cout !== ec) begin
          errors++;
          $display("FAIL result_%h_%h_%b: sum=%h cout=%b expected %h %b",
                   ta, tb_v, tc, sum, cout, es, ec);
        end
      end
    end
    prev_sum = es;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== es || cout !== ec) begin
      errors++;
      $display("FAIL hold_%h_%h: busy=%b done=%b sum=%h cout=%b expected 0 0 %h %b",
               ta, tb_v, busy, done, sum, cout, es, ec);
    end
  endtask

  task automatic test_basic();
    test_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    test_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    test_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    test_op(8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0);
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
      if (cyc == 3) begin
        a = 8'h77; b = 8'h77;
      end
      if (cyc == 8) begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || sum !== 8'h30 || cout !== 1'b0) begin
          errors++;
          $display("FAIL b2b_first: done=%b busy=%b sum=%h cout=%b expected 1 0 30 0",
                   done, busy, sum, cout);
        end
      end
      if (cyc == 9) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || sum !== 8'h30) begin
          errors++;
          $display("FAIL b2b_reaccept: busy=%b done=%b sum=%h expected 1 0 30",
                   busy, done, sum);
        end
      end
      if (cyc == 12) start = 1'b0;
      if (cyc == 17) begin
        checks++;
        if (done !== 1'b1 || sum !== 8'hEE || cout !== 1'b0) begin
          errors++;
          $display("FAIL b2b_second: done=%b sum=%h cout=%b expected 1 ee 0",
                   done, sum, cout);
        end
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d expected 2", pulses);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b done=%b expected 0 0", busy, done);
    end
    prev_sum = 8'hEE;
  endtask

  task automatic test_async_reset();
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (busy !== 1'b1 || sum !== 8'hEE) begin
      errors++;
      $display("FAIL pre_abort: busy=%b sum=%h expected 1 ee", busy, sum);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      errors++;
      $display("FAIL async_abort: busy=%b done=%b sum=%h cout=%b expected 0 0 00 0",
               busy, done, sum, cout);
    end
    @(posedge clk);
    #3 reset = 1'b0;
    prev_sum = 8'h00;
    test_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0);
  endtask

  task automatic test_width2_sweep();
    int         dones;
    logic [4:0] k;
    logic [2:0] exp_v;
    dones = 0;
    k = 5'd0;
    a2 = k[4:3]; b2 = k[2:1]; cin2 = k[0]; start2 = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 32; n++) begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      exp_v = 3'(a2) + 3'(b2) + 3'(cin2);
      if (done2 === 1'b1) dones++;
      checks++;
      if ({cout2, sum2} !== exp_v) begin
        errors++;
        $display("FAIL w2_op%0d: {cout,sum}=%b expected %b", n, {cout2, sum2}, exp_v);
      end
      if (n < 31) begin
        k = 5'(n + 1);
        a2 = k[4:3]; b2 = k[2:1]; cin2 = k[0];
      end else begin
        start2 = 1'b0;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (dones != 32) begin
      errors++;
      $display("FAIL w2_done_count: got %0d expected 32", dones);
    end
    checks++;
    if (busy2 !== 1'b0 || done2 !== 1'b0) begin
      errors++;
      $display("FAIL w2_idle: busy=%b done=%b expected 0 0", busy2, done2);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    prev_sum = 8'h00;
    reset = 1'b1;
    start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_async_reset();
    test_width2_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
